// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage MIPS pipeline.
// Performs byte/half/word loads and stores against an internal synchronous
// data memory (big-endian byte lanes) and registers the result for writeback.
// Optional build macro: MS_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses are flagged and suppressed
//   undefined -> no detection; half uses addr[1], word is aligned down

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module memory_stage #(
    parameter int DEPTH  = 256,
    parameter int AWIDTH = 8
) (
    input  logic                     ms_i_clk,
    input  logic                     ms_i_rst_n,
    input  logic                     ms_i_ce,
    input  logic [`OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [`DWIDTH-1:0]       ms_i_alu_value,
    input  logic [`DWIDTH-1:0]       ms_i_data_rt,
    input  logic [4:0]               ms_i_rd_addr,
    input  logic                     ms_i_reg_wr,
    input  logic                     ms_i_stall,
    input  logic                     ms_i_flush,
    output logic                     ms_o_ce,
    output logic [`OPCODE_WIDTH-1:0] ms_o_opcode,
    output logic [`DWIDTH-1:0]       ms_o_data,
    output logic [4:0]               ms_o_rd_addr,
    output logic                     ms_o_reg_wr,
    output logic                     ms_o_misalign
);

    localparam logic [`OPCODE_WIDTH-1:0] OP_LB  = `OPCODE_WIDTH'(6'h20);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LH  = `OPCODE_WIDTH'(6'h21);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LW  = `OPCODE_WIDTH'(6'h23);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LBU = `OPCODE_WIDTH'(6'h24);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LHU = `OPCODE_WIDTH'(6'h25);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SB  = `OPCODE_WIDTH'(6'h28);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SH  = `OPCODE_WIDTH'(6'h29);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SW  = `OPCODE_WIDTH'(6'h2B);

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic  is_load;
    logic  is_store;
    logic  is_signed;
    size_e size;

    // Classify the opcode into load/store, access size and extension kind
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (ms_i_opcode)
            OP_LB:   begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_B; end
            OP_LH:   begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_H; end
            OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
            OP_LBU:  begin is_load  = 1'b1; size = SZ_B; end
            OP_LHU:  begin is_load  = 1'b1; size = SZ_H; end
            OP_SB:   begin is_store = 1'b1; size = SZ_B; end
            OP_SH:   begin is_store = 1'b1; size = SZ_H; end
            OP_SW:   begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Address split: word index wraps modulo DEPTH, lane is big-endian
    // ------------------------------------------------------------------
    logic [AWIDTH-1:0] word_idx;
    logic [1:0]        lane_raw;
    logic [1:0]        lane;
    logic              misalign;

    assign word_idx = ms_i_alu_value[AWIDTH+1:2];
    assign lane_raw = ms_i_alu_value[1:0];

    // Align the lane down to the access size; for aligned accesses this is
    // a no-op, and without the checker it defines the aligned-down behaviour
    always_comb begin
        case (size)
            SZ_H:    lane = {lane_raw[1], 1'b0};
            SZ_W:    lane = 2'b00;
            default: lane = lane_raw;
        endcase
    end

`ifdef MS_MISALIGN_CHECK_EN
    assign misalign = (is_load || is_store) &&
                      (((size == SZ_H) && lane_raw[0]) ||
                       ((size == SZ_W) && (lane_raw != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Store path: per-byte enables, data replicated into every lane
    // ------------------------------------------------------------------
    logic [3:0]         byte_en;
    logic [`DWIDTH-1:0] wr_data;
    logic               mem_we;

    // Build byte enables (bit 3 = lane 0 = bits 31:24) and lane-replicated data
    always_comb begin
        byte_en = 4'b0000;
        wr_data = ms_i_data_rt;
        case (size)
            SZ_B: begin
                byte_en[~lane] = 1'b1;
                wr_data        = {4{ms_i_data_rt[7:0]}};
            end
            SZ_H: begin
                byte_en = lane[1] ? 4'b0011 : 4'b1100;
                wr_data = {2{ms_i_data_rt[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = ms_i_data_rt;
            end
        endcase
    end

    // A store commits only on an unstalled, unflushed edge outside reset
    assign mem_we = ms_i_rst_n && ms_i_ce && !ms_i_flush && !ms_i_stall &&
                    is_store && !misalign;

    logic [`DWIDTH-1:0] mem [DEPTH];

    // Byte-enabled memory write; contents are deliberately not reset
    always_ff @(posedge ms_i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && byte_en[b]) begin
                mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: read the addressed word, extract and extend the lane.
    // The read result is captured by the output register, so a load on the
    // edge after a store to the same word sees the new contents.
    // ------------------------------------------------------------------
    logic [`DWIDTH-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [`DWIDTH-1:0] load_val;

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{~lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[15:0] : rd_word[31:16];

    // Sign- or zero-extend the extracted byte/half
    always_comb begin
        case (size)
            SZ_B:    load_val = is_signed ? {{24{rd_byte[7]}}, rd_byte}
                                          : {24'd0, rd_byte};
            SZ_H:    load_val = is_signed ? {{16{rd_half[15]}}, rd_half}
                                          : {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state of the pipeline register
    // ------------------------------------------------------------------
    logic [`DWIDTH-1:0] nxt_data;
    logic               nxt_reg_wr;
    logic               nxt_misalign;

    // Select the writeback value and suppress reg writes for stores/faults
    always_comb begin
        nxt_data     = ms_i_alu_value;
        nxt_reg_wr   = ms_i_reg_wr;
        nxt_misalign = 1'b0;
        if (misalign) begin
            nxt_data     = '0;
            nxt_reg_wr   = 1'b0;
            nxt_misalign = 1'b1;
        end else if (is_load) begin
            nxt_data = load_val;
        end else if (is_store) begin
            nxt_reg_wr = 1'b0;
        end
    end

    // Pipeline register: flush beats stall, stall holds, ce=0 inserts a bubble
    always_ff @(posedge ms_i_clk or negedge ms_i_rst_n) begin
        if (!ms_i_rst_n) begin
            ms_o_ce       <= 1'b0;
            ms_o_opcode   <= '0;
            ms_o_data     <= '0;
            ms_o_rd_addr  <= '0;
            ms_o_reg_wr   <= 1'b0;
            ms_o_misalign <= 1'b0;
        end else if (ms_i_flush || (!ms_i_stall && !ms_i_ce)) begin
            ms_o_ce       <= 1'b0;
            ms_o_opcode   <= '0;
            ms_o_data     <= '0;
            ms_o_rd_addr  <= '0;
            ms_o_reg_wr   <= 1'b0;
            ms_o_misalign <= 1'b0;
        end else if (!ms_i_stall) begin
            ms_o_ce       <= 1'b1;
            ms_o_opcode   <= ms_i_opcode;
            ms_o_data     <= nxt_data;
            ms_o_rd_addr  <= ms_i_rd_addr;
            ms_o_reg_wr   <= nxt_reg_wr;
            ms_o_misalign <= nxt_misalign;
        end
    end

endmodule
